// File: rtl/fault_fsm.sv
// Persistence-filtered fault supervisor: debounces four fault flags and escalates NORMAL->WARNING->FAULT->SHUTDOWN.
// Optional build macro FAULT_FSM_AUTO_RECOVER_EN lets WARNING fall back to NORMAL once every counter is zero.
module fault_fsm #(
  parameter int WARN_CYCLES     = 4,
  parameter int FAULT_CYCLES    = 16,
  parameter int SHUTDOWN_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ov,
  input  logic       uv,
  input  logic       ot,
  input  logic       uc,
  input  logic       mask_ov,
  input  logic       mask_uv,
  input  logic       mask_ot,
  input  logic       mask_uc,
  input  logic       clear_warning,
  output logic [1:0] state,
  output logic       warn,
  output logic       fault,
  output logic       shutdown,
  output logic [2:0] active_fault_id,
  output logic [7:0] cnt_uv,
  output logic [7:0] cnt_ov,
  output logic [7:0] cnt_ot,
  output logic [7:0] cnt_uc
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    WARNING  = 2'd1,
    FAULT    = 2'd2,
    SHUTDOWN = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [3:0]      eff;
  logic [3:0][7:0] cnt_all;
  logic [7:0]      max_cnt;
  logic            all_zero;

  // Channel order: 0 uv, 1 ov, 2 ot, 3 uc.
  assign eff = {uc & ~mask_uc, ot & ~mask_ot, ov & ~mask_ov, uv & ~mask_uv};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [7:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst || !eff[gi]) begin
          cnt_reg <= 8'd0;
        end else if (cnt_reg != 8'hFF) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  always_comb begin
    max_cnt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (cnt_all[i] > max_cnt) max_cnt = cnt_all[i];
    end
  end

  assign all_zero = (cnt_all == '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= NORMAL;
    else     state_reg <= state_next;
  end

  // Escalation is tested first so it always wins over a clear on the same edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NORMAL: begin
        if (max_cnt >= 8'(WARN_CYCLES)) state_next = WARNING;
      end
      WARNING: begin
        if (max_cnt >= 8'(FAULT_CYCLES)) state_next = FAULT;
`ifdef FAULT_FSM_AUTO_RECOVER_EN
        else if (all_zero) state_next = NORMAL;
`else
        else if (clear_warning && all_zero) state_next = NORMAL;
`endif
      end
      FAULT: begin
        if (max_cnt >= 8'(SHUTDOWN_CYCLES)) state_next = SHUTDOWN;
        else if (clear_warning && all_zero) state_next = NORMAL;
      end
      SHUTDOWN: state_next = SHUTDOWN;
      default:  state_next = NORMAL;
    endcase
  end

  assign state    = state_reg;
  assign warn     = (state_reg == WARNING);
  assign fault    = (state_reg == FAULT);
  assign shutdown = (state_reg == SHUTDOWN);

  // Reporting priority OT > OV > UV > UC.
  always_comb begin
    active_fault_id = 3'd0;
    if      (cnt_all[2] != 8'd0) active_fault_id = 3'd3;
    else if (cnt_all[1] != 8'd0) active_fault_id = 3'd2;
    else if (cnt_all[0] != 8'd0) active_fault_id = 3'd1;
    else if (cnt_all[3] != 8'd0) active_fault_id = 3'd4;
  end

  assign cnt_uv = cnt_all[0];
  assign cnt_ov = cnt_all[1];
  assign cnt_ot = cnt_all[2];
  assign cnt_uc = cnt_all[3];

endmodule

// File: tb/tb_fault_fsm.sv
// Self-checking bench for fault_fsm: a vector table plus hand-written multi-cycle sequences, checked through a queue.
module tb_fault_fsm;
  localparam int W = 4;
  localparam int F = 16;
  localparam int S = 32;

  // Flag/mask nibble layout: [3] ov, [2] uv, [1] ot, [0] uc.
  localparam logic [3:0] N_OV = 4'b1000;
  localparam logic [3:0] N_UV = 4'b0100;
  localparam logic [3:0] N_OT = 4'b0010;
  localparam logic [3:0] N_UC = 4'b0001;
  localparam logic [3:0] N_NO = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ov = 1'b0, uv = 1'b0, ot = 1'b0, uc = 1'b0;
  logic mask_ov = 1'b0, mask_uv = 1'b0, mask_ot = 1'b0, mask_uc = 1'b0;
  logic clear_warning = 1'b0;
  logic [1:0] state;
  logic warn, fault, shutdown;
  logic [2:0] active_fault_id;
  logic [7:0] cnt_uv, cnt_ov, cnt_ot, cnt_uc;

  fault_fsm #(.WARN_CYCLES(W), .FAULT_CYCLES(F), .SHUTDOWN_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .ov(ov), .uv(uv), .ot(ot), .uc(uc),
    .mask_ov(mask_ov), .mask_uv(mask_uv), .mask_ot(mask_ot), .mask_uc(mask_uc),
    .clear_warning(clear_warning),
    .state(state), .warn(warn), .fault(fault), .shutdown(shutdown),
    .active_fault_id(active_fault_id),
    .cnt_uv(cnt_uv), .cnt_ov(cnt_ov), .cnt_ot(cnt_ot), .cnt_uc(cnt_uc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] fl;
    logic [3:0] mk;
    logic       c;
    logic [1:0] es;
    logic [2:0] eid;
    logic [7:0] euv, eov, eot, euc;
  } vec_t;

  typedef struct {
    logic [1:0] es;
    logic [2:0] eid;
    logic [7:0] euv, eov, eot, euc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_step  = 0;

  // Expected state after edge i when one flag is held from edge 0, starting in NORMAL with zero counters.
  function automatic logic [1:0] esc(input int i);
    if (i >= S) return 2'd3;
    if (i >= F) return 2'd2;
    if (i >= W) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic step(input logic r, input logic [3:0] fl, input logic [3:0] mk, input logic c,
                      input logic [1:0] es, input logic [2:0] eid,
                      input logic [7:0] euv, input logic [7:0] eov, input logic [7:0] eot, input logic [7:0] euc,
                      input string tag);
    exp_t e;
    logic [39:0] act, req;
    @(negedge clk);
    rst = r;
    {ov, uv, ot, uc} = fl;
    {mask_ov, mask_uv, mask_ot, mask_uc} = mk;
    clear_warning = c;
    e.es = es; e.eid = eid; e.euv = euv; e.eov = eov; e.eot = eot; e.euc = euc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_step++;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s step %0d: scoreboard empty", tag, n_step);
      return;
    end
    e = sb.pop_front();
    act = {state, warn, fault, shutdown, active_fault_id, cnt_uv, cnt_ov, cnt_ot, cnt_uc};
    req = {e.es, e.es == 2'd1, e.es == 2'd2, e.es == 2'd3, e.eid, e.euv, e.eov, e.eot, e.euc};
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got st=%0d wfs=%b%b%b id=%0d uv/ov/ot/uc=%0d/%0d/%0d/%0d, required st=%0d id=%0d uv/ov/ot/uc=%0d/%0d/%0d/%0d",
               tag, n_step, state, warn, fault, shutdown, active_fault_id, cnt_uv, cnt_ov, cnt_ot, cnt_uc,
               e.es, e.eid, e.euv, e.eov, e.eot, e.euc);
    end else begin
      $display("[TB] %s step %0d ok st=%0d id=%0d uv/ov/ot/uc=%0d/%0d/%0d/%0d",
               tag, n_step, state, active_fault_id, cnt_uv, cnt_ov, cnt_ot, cnt_uc);
    end
  endtask

  vec_t tbl[8];
  logic [1:0] latched;

  initial begin
    //            r     flags          mask  clr  st    id    uv     ov     ot     uc
    tbl[0] = '{1'b1, N_NO,           N_NO, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[1] = '{1'b0, N_UC,           N_NO, 1'b0, 2'd0, 3'd4, 8'd0, 8'd0, 8'd0, 8'd1};
    tbl[2] = '{1'b0, N_NO,           N_NO, 1'b1, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[3] = '{1'b0, N_OV | N_OT,    N_NO, 1'b0, 2'd0, 3'd3, 8'd0, 8'd1, 8'd1, 8'd0};
    tbl[4] = '{1'b0, N_OV,           N_NO, 1'b0, 2'd0, 3'd2, 8'd0, 8'd2, 8'd0, 8'd0};
    tbl[5] = '{1'b0, N_UV | N_UC,    N_NO, 1'b0, 2'd0, 3'd1, 8'd1, 8'd0, 8'd0, 8'd1};
    tbl[6] = '{1'b0, N_UV | N_UC,    N_UV, 1'b0, 2'd0, 3'd4, 8'd0, 8'd0, 8'd0, 8'd2};
    tbl[7] = '{1'b0, N_NO,           N_NO, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++)
      step(tbl[i].r, tbl[i].fl, tbl[i].mk, tbl[i].c, tbl[i].es, tbl[i].eid,
           tbl[i].euv, tbl[i].eov, tbl[i].eot, tbl[i].euc, "table");

    // Masked uc never counts.
    for (int i = 0; i < 20; i++)
      step(1'b0, N_UC, N_UC, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "mask");

    // Persistent OV for 20 cycles, then drop with clear held for 2 cycles.
    for (int i = 0; i < 20; i++)
      step(1'b0, N_OV, N_NO, 1'b0, esc(i), 3'd2, 8'd0, 8'(i + 1), 8'd0, 8'd0, "ov_persist");
    step(1'b0, N_NO, N_NO, 1'b1, 2'd2, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "ov_clear");
    step(1'b0, N_NO, N_NO, 1'b1, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "ov_clear");

    // WARNING latches without clear (falls back on its own only in the auto-recover build).
    for (int i = 0; i < 5; i++)
      step(1'b0, N_UV, N_NO, 1'b0, esc(i), 3'd1, 8'(i + 1), 8'd0, 8'd0, 8'd0, "warn_latch");
    for (int j = 0; j < 3; j++) begin
`ifdef FAULT_FSM_AUTO_RECOVER_EN
      latched = (j == 0) ? 2'd1 : 2'd0;
`else
      latched = 2'd1;
`endif
      step(1'b0, N_NO, N_NO, 1'b0, latched, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "warn_hold");
    end
    step(1'b0, N_NO, N_NO, 1'b1, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "warn_clear");

    // OV+OT together: OT wins priority; clear while OT is still high is ignored; reset mid-FAULT.
    for (int i = 0; i < 10; i++)
      step(1'b0, N_OV | N_OT, N_NO, 1'b0, esc(i), 3'd3, 8'd0, 8'(i + 1), 8'(i + 1), 8'd0, "ov_ot");
    step(1'b0, N_OT, N_NO, 1'b1, 2'd1, 3'd3, 8'd0, 8'd0, 8'd11, 8'd0, "ot_clr_ignored");
    for (int i = 11; i < 18; i++)
      step(1'b0, N_OT, N_NO, 1'b0, esc(i), 3'd3, 8'd0, 8'd0, 8'(i + 1), 8'd0, "ot_persist");
    step(1'b1, N_OT, N_NO, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "rst_mid_fault");
    for (int i = 0; i < 3; i++)
      step(1'b0, N_OT, N_NO, 1'b0, 2'd0, 3'd3, 8'd0, 8'd0, 8'(i + 1), 8'd0, "resume");
    step(1'b0, N_NO, N_NO, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "idle");

    // Persistent UC reaches SHUTDOWN, which only reset can leave.
    for (int i = 0; i < 40; i++)
      step(1'b0, N_UC, N_NO, 1'b0, esc(i), 3'd4, 8'd0, 8'd0, 8'd0, 8'(i + 1), "uc_persist");
    step(1'b0, N_NO, N_NO, 1'b1, 2'd3, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "sd_clear");
    step(1'b0, N_NO, N_NO, 1'b0, 2'd3, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "sd_hold");
    step(1'b0, N_NO, N_NO, 1'b1, 2'd3, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "sd_clear");
    step(1'b1, N_NO, N_NO, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "sd_rst");
    step(1'b0, N_NO, N_NO, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "sd_after");

    // Counter saturation at 255.
    for (int i = 0; i < 260; i++)
      step(1'b0, N_UV, N_NO, 1'b0, esc(i), 3'd1, sat(i + 1), 8'd0, 8'd0, 8'd0, "saturate");
    step(1'b1, N_UV, N_NO, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, "sat_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
